// File: rtl/cjg_stack_pkg.sv
// Shared definitions for the hardware stack: op encoding and pointer width helper.
package cjg_stack_pkg;

  // Operation code formed as {push, pop}.
  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_PUSH = 2'b10;
  localparam logic [1:0] OP_REPL = 2'b11;

  // Stack pointer width: one extra bit so the count can reach DEPTH.
  function automatic int unsigned sp_width(input int unsigned addrw);
    return addrw + 1;
  endfunction

endpackage

// File: rtl/cjg_stack_ram.sv
// Stack storage: register array with one write port and an asynchronous read port.
module cjg_stack_ram #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned ADDRW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [ADDRW-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [ADDRW-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; reset is the only thing that zeroes storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Asynchronous read of the entry below the current top.
  always_comb rdata = mem[raddr];

endmodule

// File: rtl/cjg_hw_stack.sv
// LIFO call/data stack with internal pointer, registered top-of-stack and sticky error flags.
module cjg_hw_stack
  import cjg_stack_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 32,
  parameter int unsigned ADDRW = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic             err_clr,
  output logic [WIDTH-1:0] q,
  output logic [ADDRW:0]   sp,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow,
  input  logic             scan_in0,
  input  logic             scan_en,
  input  logic             test_mode,
  output logic             scan_out0
);

  localparam int unsigned SPW = sp_width(ADDRW);

  logic [1:0]       op;
  logic [SPW-1:0]   sp_n;
  logic [WIDTH-1:0] q_n;
  logic             ov_n;
  logic             un_n;
  logic             we;
  logic [ADDRW-1:0] waddr;
  logic [ADDRW-1:0] raddr;
  logic [WIDTH-1:0] rdata;
  logic             unused_dft;

  assign unused_dft = &{1'b0, scan_in0, scan_en, test_mode};
  assign scan_out0  = 1'b0;

  assign op    = {push, pop};
  assign empty = (sp == '0);
  assign full  = (sp == SPW'(DEPTH));
  assign raddr = ADDRW'(sp - SPW'(2));

  cjg_stack_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDRW (ADDRW)
  ) u_ram (
    .clk   (clk),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (d),
    .raddr (raddr),
    .rdata (rdata)
  );

  // Next-state decode: clear dominates, then the stack op, with new errors beating err_clr.
  always_comb begin
    sp_n  = sp;
    q_n   = q;
    ov_n  = overflow;
    un_n  = underflow;
    we    = 1'b0;
    waddr = ADDRW'(sp);
    if (clear) begin
      sp_n = '0;
      q_n  = '0;
      ov_n = 1'b0;
      un_n = 1'b0;
    end else begin
      if (err_clr) begin
        ov_n = 1'b0;
        un_n = 1'b0;
      end
      case (op)
        OP_PUSH: begin
          if (full) begin
            ov_n = 1'b1;
          end else begin
            we   = 1'b1;
            sp_n = sp + SPW'(1);
            q_n  = d;
          end
        end
        OP_POP: begin
          if (empty) begin
            un_n = 1'b1;
          end else begin
            sp_n = sp - SPW'(1);
            q_n  = (sp >= SPW'(2)) ? rdata : '0;
          end
        end
        OP_REPL: begin
          // Replace-top on an empty stack degenerates to a plain push.
          we  = 1'b1;
          q_n = d;
          if (empty) begin
            sp_n = SPW'(1);
          end else begin
            waddr = ADDRW'(sp - SPW'(1));
          end
        end
        default: ;
      endcase
    end
  end

  // Pointer, top-of-stack and flag registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp        <= '0;
      q         <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_n;
      q         <= q_n;
      overflow  <= ov_n;
      underflow <= un_n;
    end
  end

endmodule

// File: tb/tb_cjg_hw_stack.sv
// Directed self-checking bench for cjg_hw_stack (DEPTH=4, WIDTH=32).
module tb_cjg_hw_stack;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned ADDRW = 2;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] d;
  logic             push, pop, clear, err_clr;
  logic [WIDTH-1:0] q;
  logic [ADDRW:0]   sp;
  logic             empty, full, overflow, underflow;
  logic             scan_in0, scan_en, test_mode, scan_out0;

  int nchecks = 0;
  int nerrors = 0;

  // Reference stack model
  logic [WIDTH-1:0] ms[$];
  logic             m_ov, m_un;

  cjg_hw_stack #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .ADDRW (ADDRW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .d         (d),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .err_clr   (err_clr),
    .q         (q),
    .sp        (sp),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow),
    .scan_in0  (scan_in0),
    .scan_en   (scan_en),
    .test_mode (test_mode),
    .scan_out0 (scan_out0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare every visible output against the model.
  task automatic chk_model(input string tag);
    logic [WIDTH-1:0] eq;
    eq = (ms.size() > 0) ? ms[ms.size()-1] : '0;
    chk({tag, ".q"},   64'(q), 64'(eq));
    chk({tag, ".sp"},  64'(sp), 64'(ms.size()));
    chk({tag, ".emp"}, 64'(empty), 64'(ms.size() == 0));
    chk({tag, ".ful"}, 64'(full), 64'(ms.size() == DEPTH));
    chk({tag, ".ov"},  64'(overflow), 64'(m_ov));
    chk({tag, ".un"},  64'(underflow), 64'(m_un));
    chk({tag, ".so"},  64'(scan_out0), 64'(0));
  endtask

  // One clocked request, then model update and full comparison.
  task automatic step(input string tag, input logic p, input logic po, input logic c,
                      input logic e, input logic [WIDTH-1:0] dd);
    @(negedge clk);
    push = p; pop = po; clear = c; err_clr = e; d = dd;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0; d = '0;
    if (c) begin
      ms.delete();
      m_ov = 1'b0;
      m_un = 1'b0;
    end else begin
      if (e) begin
        m_ov = 1'b0;
        m_un = 1'b0;
      end
      case ({p, po})
        2'b10: if (ms.size() < DEPTH) ms.push_back(dd); else m_ov = 1'b1;
        2'b01: if (ms.size() > 0) void'(ms.pop_back()); else m_un = 1'b1;
        2'b11: if (ms.size() == 0) ms.push_back(dd); else ms[ms.size()-1] = dd;
        default: ;
      endcase
    end
    chk_model(tag);
  endtask

  initial begin
    reset = 1'b0;
    d = '0; push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0;
    scan_in0 = 1'b0; scan_en = 1'b0; test_mode = 1'b0;
    m_ov = 1'b0; m_un = 1'b0;
    #12;
    reset = 1'b1;

    // Reset state and idle
    chk_model("rst");
    for (int i = 0; i < 3; i++) step("idle", 1'b0, 1'b0, 1'b0, 1'b0, '0);
    chk("idle_q", 64'(q), 64'h0);
    chk("idle_empty", 64'(empty), 64'h1);

    // Fill, overflow, err_clr
    step("push1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h11);
    chk("push1_sp", 64'(sp), 64'd1);
    step("push2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h22);
    step("push3", 1'b1, 1'b0, 1'b0, 1'b0, 32'h33);
    step("push4", 1'b1, 1'b0, 1'b0, 1'b0, 32'h44);
    chk("push4_full", 64'(full), 64'h1);
    chk("push4_q", 64'(q), 64'h44);
    step("push5", 1'b1, 1'b0, 1'b0, 1'b0, 32'h55);
    chk("ovf_set", 64'(overflow), 64'h1);
    chk("ovf_q", 64'(q), 64'h44);
    chk("ovf_sp", 64'(sp), 64'd4);
    step("eclr", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("ovf_clr", 64'(overflow), 64'h0);

    // Drain, underflow
    step("pop1", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("pop1_q", 64'(q), 64'h33);
    step("pop2", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("pop2_q", 64'(q), 64'h22);
    step("pop3", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("pop3_q", 64'(q), 64'h11);
    step("pop4", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("pop4_q", 64'(q), 64'h0);
    chk("pop4_empty", 64'(empty), 64'h1);
    step("pop5", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("unf_set", 64'(underflow), 64'h1);
    chk("unf_sp", 64'(sp), 64'd0);
    step("eclr2", 1'b0, 1'b0, 1'b0, 1'b1, '0);
    chk("unf_clr", 64'(underflow), 64'h0);

    // New error in same cycle as err_clr: set wins
    step("pop_eclr", 1'b0, 1'b1, 1'b0, 1'b1, '0);
    chk("setwins", 64'(underflow), 64'h1);
    step("eclr3", 1'b0, 1'b0, 1'b0, 1'b1, '0);

    // Replace-top on empty behaves as push, no underflow
    step("repl_emp", 1'b1, 1'b1, 1'b0, 1'b0, 32'h5);
    chk("repl_emp_sp", 64'(sp), 64'd1);
    chk("repl_emp_un", 64'(underflow), 64'h0);
    step("pop_r", 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Replace-top with sp=2
    step("pushA", 1'b1, 1'b0, 1'b0, 1'b0, 32'hA);
    step("pushB", 1'b1, 1'b0, 1'b0, 1'b0, 32'hB);
    step("replC", 1'b1, 1'b1, 1'b0, 1'b0, 32'hC);
    chk("replC_sp", 64'(sp), 64'd2);
    chk("replC_q", 64'(q), 64'hC);
    step("popC", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("popC_q", 64'(q), 64'hA);
    step("pushE", 1'b1, 1'b0, 1'b0, 1'b0, 32'hE);
    step("pushF", 1'b1, 1'b0, 1'b0, 1'b0, 32'hF);
    step("pushG", 1'b1, 1'b0, 1'b0, 1'b0, 32'h10);
    step("replD", 1'b1, 1'b1, 1'b0, 1'b0, 32'hD);
    chk("replD_sp", 64'(sp), 64'd4);
    chk("replD_q", 64'(q), 64'hD);
    chk("replD_ov", 64'(overflow), 64'h0);
    step("popD", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("popD_q", 64'(q), 64'hF);

    // sp=3 with overflow set, then clear with push
    step("pushH", 1'b1, 1'b0, 1'b0, 1'b0, 32'h20);
    step("ovf2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h21);
    step("pop_s3", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    chk("s3_sp", 64'(sp), 64'd3);
    chk("s3_ov", 64'(overflow), 64'h1);
    step("clr_push", 1'b1, 1'b0, 1'b1, 1'b0, 32'h99);
    chk("clr_sp", 64'(sp), 64'd0);
    chk("clr_q", 64'(q), 64'h0);
    chk("clr_ov", 64'(overflow), 64'h0);
    step("push77", 1'b1, 1'b0, 1'b0, 1'b0, 32'h77);
    chk("p77_sp", 64'(sp), 64'd1);
    chk("p77_q", 64'(q), 64'h77);

    // Asynchronous reset during a push burst
    step("burst1", 1'b1, 1'b0, 1'b0, 1'b0, 32'h2);
    step("burst2", 1'b1, 1'b0, 1'b0, 1'b0, 32'h3);
    @(negedge clk);
    push = 1'b1; d = 32'h4;
    #2;
    reset = 1'b0;
    #1;
    chk("arst_q", 64'(q), 64'h0);
    chk("arst_sp", 64'(sp), 64'd0);
    chk("arst_empty", 64'(empty), 64'h1);
    chk("arst_full", 64'(full), 64'h0);
    chk("arst_ov", 64'(overflow), 64'h0);
    chk("arst_un", 64'(underflow), 64'h0);
    @(posedge clk);
    #1;
    chk("arst_hold_sp", 64'(sp), 64'd0);
    push = 1'b0; d = '0;
    @(negedge clk);
    reset = 1'b1;
    ms.delete();
    m_ov = 1'b0;
    m_un = 1'b0;
    step("post_rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'h1);
    chk("post_rst_sp", 64'(sp), 64'd1);
    chk("post_rst_q", 64'(q), 64'h1);

    $display("Result: errors=%0d of %0d checks", nerrors, nchecks);
    $finish;
  end

endmodule

// File: doc/cjg_hw_stack.md
Name: cjg_hw_stack

Overview:
- Parametrised LIFO call/data stack with an internal stack pointer, replacing externally-addressed stack memory.
- Sits beside the CPU control unit, serving CALL/RET and PUSH/POP.
- Keeps a registered top-of-stack and full/empty status.
- Supports push, pop, simultaneous replace-top and clear; raises sticky overflow/underflow error flags for the exception logic.

Parameters:
- WIDTH, 32, data word width in bits.
- DEPTH, 32, number of stack entries; 2 <= DEPTH <= 2**ADDRW.
- ADDRW, 5, storage index width; must equal clog2(DEPTH).

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- d  input  WIDTH  data to push.
- push  input  1  push request.
- pop  input  1  pop request.
- clear  input  1  synchronous stack flush.
- err_clr  input  1  clears the sticky error flags.
- q  output  WIDTH  registered top-of-stack value; 0 when empty.
- sp  output  ADDRW+1  entry count, range 0..DEPTH.
- empty  output  1  high when sp == 0.
- full  output  1  high when sp == DEPTH.
- overflow  output  1  sticky; set by a push while full.
- underflow  output  1  sticky; set by a pop while empty.
- scan_in0  input  1  DFT hook; unused in RTL.
- scan_en  input  1  DFT hook; unused in RTL.
- test_mode  input  1  DFT hook; unused in RTL.
- scan_out0  output  1  DFT hook; driven 0 in RTL.

Behaviour:
- Reset (reset low, async): q=0, sp=0, overflow=0, underflow=0, every storage entry=0. Hence empty=1 and full=0.
- All state changes occur on the rising clk edge. Results are visible on the cycle after the request; there are no bubbles, and one operation is accepted per cycle.
- empty and full are combinational decodes of the sp register.
- Priority order: clear, then push/pop, then err_clr.
- clear:
  - sp<=0, q<=0, overflow<=0, underflow<=0.
  - Storage contents are retained; only reset zeroes storage.
  - Any push/pop in the same cycle is ignored and sets no flags.
- push only, not full: mem[sp]<=d, sp<=sp+1, q<=d.
- push only, full: no state change, overflow<=1.
- pop only, not empty:
  - sp<=sp-1.
  - q<=mem[sp-2] when sp>=2, else q<=0.
  - The popped value is the q present before the edge; the consumer samples q in the same cycle it asserts pop.
- pop only, empty: no state change, underflow<=1.
- push and pop together (replace-top):
  - Not empty: mem[sp-1]<=d, q<=d, sp unchanged. This is legal when full and sets no flag.
  - Empty: behaves as push only, and underflow is not set.
- err_clr: clears overflow and underflow. If the same cycle produces a new error, the set wins.
- Idle (no request): all state holds.
- Arithmetic: sp is unsigned, ADDRW+1 bits, and never wraps. Storage index = sp[ADDRW-1:0] or (sp-1)/(sp-2) truncated, used only when the guards above hold.
- q always equals mem[sp-1] when sp>0. The bench checks this invariant every cycle.
- Reset asserted mid-operation aborts any in-flight request; the state returns to the reset values immediately.

Decomposition:
- Shared package cjg_stack_pkg:
  - Op encoding constants OP_NONE, OP_PUSH, OP_POP, OP_REPL, derived from {push,pop}.
  - A localparam helper for the sp width (ADDRW+1).
- One natural sub-module, cjg_stack_ram:
  - WIDTH x DEPTH register array.
  - One write port and one asynchronous read port, with async-reset clear.
- cjg_hw_stack holds the pointer, the q register, the flag logic and the op decode.

Test Plan (DEPTH=4, WIDTH=32 unless noted):
- Reset then idle 3 cycles -> q=0, sp=0, empty=1, full=0, overflow=0, underflow=0.
- Push 0x11,0x22,0x33,0x44 on consecutive cycles -> sp=1..4, q follows each value, full=1 after the 4th push. A 5th push of 0x55 -> sp=4, q=0x44, overflow=1. A following err_clr -> overflow=0.
- From full, pop 4 times -> q sequence 0x33,0x22,0x11,0 and sp 3,2,1,0, empty=1. A 5th pop -> sp=0, underflow=1, q=0.
- sp=2 (0xA,0xB), push+pop with d=0xC -> sp=2, q=0xC. Then pop -> q=0xA. When full, push+pop with d=0xD -> sp=4, q=0xD, no overflow.
- sp=3 with overflow set, assert clear together with push d=0x99 -> sp=0, q=0, flags=0. The next push of 0x77 -> sp=1, q=0x77.
- Assert reset low asynchronously mid-cycle during a push burst -> outputs go to reset values before the next edge. After release, push 0x1 -> sp=1, q=0x1.
